ntt_iter: RTL
=============

Name: ntt_iter

Overview:
- Iterative, sequential successor to the combinational `ntt` block.
- Computes a D-point forward number-theoretic transform over Z_Q, N-bit coefficients.
- Streams one coefficient per beat in, runs radix-2 Cooley-Tukey decimation-in-time butterflies one per cycle, streams results out in natural order.
- Sits between the coefficient loader and the pointwise-multiply stage of the polynomial multiplier.

Parameters:
- N, 9: coefficient width in bits; constraint 2^(N-1) < Q < 2^N.
- D, 8: transform length; power of two, D >= 4.
- Q, 257: prime modulus; D divides Q-1.
- W, 4: primitive D-th root of unity mod Q.
- W_INV, 193: W^-1 mod Q (used only with the optional feature).
- D_INV, 225: D^-1 mod Q (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  pulse; begins a transform when idle.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  accepting input coefficient.
- in_data  in  N  input coefficient, index order 0..D-1.
- out_valid  out  1  output coefficient valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  N  output coefficient, index order 0..D-1.
- busy  out  1  high from accepted start until last output beat.
- done  out  1  one-cycle pulse on the last output handshake.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low.
- Reset: state=IDLE, all counters 0. in_ready=0, out_valid=0, out_data=0, busy=0, done=0. Coefficient memory is not cleared.
- FSM IDLE:
  - start=1 -> LOAD; busy=1 from the next cycle.
  - start is ignored in any other state.
- FSM LOAD:
  - in_ready=1.
  - Each in_valid&in_ready beat k writes reduce(in_data) to mem[bitrev(k)]; reduce(x) = x>=Q ? x-Q : x.
  - After beat D-1 -> COMPUTE; in_ready=0 in that same following cycle.
- FSM COMPUTE:
  - Exactly log2(D)*D/2 cycles (12 at defaults).
  - Stage s=0..log2(D)-1, butterfly j=0..D/2-1, half=2^s.
  - Pair indices: lo = (j/half)*2*half + (j%half), hi = lo+half.
  - Twiddle: t = W^((j%half)*(D/(2*half))).
  - Butterfly: p = mem[hi]*t mod Q; mem[lo] <= (mem[lo]+p) mod Q; mem[hi] <= (mem[lo]-p+Q) mod Q.
  - One butterfly per cycle, combinational read, registered write. No hazards, since a stage never rereads a written pair.
  - After the last butterfly -> UNLOAD.
- FSM UNLOAD:
  - out_valid=1, out_data=mem[idx], idx=0..D-1 in natural order.
  - idx advances only on out_valid&out_ready; out_data is held stable while stalled.
  - Final handshake: done=1 for one cycle, busy=0, -> IDLE.
- Latency:
  - start to first in_ready is 1 cycle.
  - Last input beat to first out_valid is log2(D)*D/2+1 cycles.
- Arithmetic:
  - Products are 2N bits wide.
  - All sums are reduced with a single conditional subtract of Q.
  - Twiddles come from a constant table W^0..W^(D/2-1), computed at elaboration by a constant function.
- Boundaries:
  - in_valid in IDLE, COMPUTE or UNLOAD is ignored.
  - in_valid gaps during LOAD stall the load counter.
  - out_ready held low stalls indefinitely with no data loss.
  - rst_n low in any state aborts the transform immediately to the reset values above; no done pulse is produced.
  - start asserted in the same cycle as done is ignored; re-issue it from IDLE.

Optional Feature:
- Macro: NTT_ITER_INTT_EN.
- Defined:
  - Extra input port `inverse` (1 bit), sampled when start is accepted and held for the whole transform.
  - inverse=1 uses the W_INV twiddle table.
  - In UNLOAD, each output is multiplied by D_INV mod Q. This adds no cycles; the multiply is combinational on the read path.
- Undefined: no inverse port, forward transform only, and the W_INV and D_INV parameters are unused.

Decomposition:
- Shared package ntt_pkg holds:
  - default N, D, Q, W, W_INV, D_INV;
  - LOGD = $clog2(D);
  - FSM state encoding (IDLE, LOAD, COMPUTE, UNLOAD);
  - constant functions bitrev() and modpow() used to build the twiddle tables.
- Sub-module ntt_butterfly: purely combinational (a, b, t) -> (a+b*t, a-b*t) mod Q, parametrised on N and Q.
- ntt_iter owns the FSM, counters, coefficient memory and twiddle ROM.

Test Plan:
- All-ones (the legacy `ntt` stimulus): load eight 1s, out_ready=1 -> outputs [8,0,0,0,0,0,0,0], done pulse, 12 compute cycles measured.
- Delta at index 1, input [0,1,0,0,0,0,0,0] -> outputs [1,4,16,64,256,253,241,193].
- Input reduction: load eight 258s (258≡1) -> outputs [8,0,...,0]; constant 5 -> [40,0,...,0].
- Backpressure and gaps: in_valid toggled every other cycle, out_ready random 50% -> identical results to the delta test; out_data stable whenever out_valid&!out_ready.
- Reset mid-COMPUTE: drop rst_n for 1 cycle at butterfly 5 -> all outputs at reset values and IDLE; a new start then gives a correct result.
- With NTT_ITER_INTT_EN: forward of [3,1,4,1,5,9,2,6], then inverse of that result -> [3,1,4,1,5,9,2,6] recovered exactly.

Source files
------------

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared defaults, FSM encoding and constant helpers for ntt_iter
package ntt_pkg;

  localparam int N_DEF     = 9;
  localparam int D_DEF     = 8;
  localparam int Q_DEF     = 257;
  localparam int W_DEF     = 4;
  localparam int W_INV_DEF = 193;
  localparam int D_INV_DEF = 225;
  localparam int LOGD      = $clog2(D_DEF);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

  function automatic int bitrev(input int k, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  function automatic int modpow(input int b, input int e, input int q);
    longint r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * longint'(b)) % longint'(q);
    return int'(r);
  endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// rtl/ntt_butterfly.sv - combinational radix-2 butterfly (a+b*t, a-b*t) mod Q
module ntt_butterfly
  import ntt_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] t,
  output logic [N-1:0] x,
  output logic [N-1:0] y
);

  localparam logic [N:0]     QN = (N+1)'(Q);
  localparam logic [2*N-1:0] Q2 = (2*N)'(Q);

  logic [2*N-1:0] prod;
  logic [N-1:0]   p;
  logic [N:0]     sum;
  logic [N:0]     diff;

  // a and p are both below Q, so one conditional subtract reduces each result
  assign prod = {{N{1'b0}}, b} * {{N{1'b0}}, t};
  assign p    = N'(prod % Q2);
  assign sum  = {1'b0, a} + {1'b0, p};
  assign diff = {1'b0, a} + QN - {1'b0, p};
  assign x    = N'((sum >= QN) ? sum - QN : sum);
  assign y    = N'((diff >= QN) ? diff - QN : diff);

endmodule

// File: rtl/ntt_iter.sv
// rtl/ntt_iter.sv - iterative D-point NTT, one butterfly per cycle; NTT_ITER_INTT_EN adds inverse mode
module ntt_iter
  import ntt_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int D     = D_DEF,
  parameter int Q     = Q_DEF,
  parameter int W     = W_DEF,
  parameter int W_INV = W_INV_DEF,
  parameter int D_INV = D_INV_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef NTT_ITER_INTT_EN
  input  logic         inverse,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic         done
);

  localparam int LG = $clog2(D);
  localparam int SW = $clog2(LG);
  localparam int HD = D / 2;
  localparam logic [N:0] QN = (N+1)'(Q);

  state_t        state;
  logic [LG-1:0] idx;
  logic [LG-2:0] bj;
  logic [SW-1:0] stg;
  logic [N-1:0]  mem [D];
  logic [N-1:0]  tw_fwd [HD];
  logic [N-1:0]  tw;
  logic [LG-1:0] lo;
  logic [LG-1:0] hi;
  logic [LG-2:0] tidx;
  logic [N-1:0]  bf_x;
  logic [N-1:0]  bf_y;
  logic [N:0]    in_ext;
  logic [N-1:0]  in_red;
  logic [N-1:0]  rdata;

  for (genvar g = 0; g < HD; g++) begin : g_tw_fwd
    assign tw_fwd[g] = N'(modpow(W, g, Q));
  end

`ifdef NTT_ITER_INTT_EN
  localparam logic [2*N-1:0] Q2  = (2*N)'(Q);
  localparam logic [2*N-1:0] DI2 = (2*N)'(D_INV);

  logic           inv_r;
  logic [N-1:0]   tw_inv [HD];
  logic [2*N-1:0] sprod;

  for (genvar g = 0; g < HD; g++) begin : g_tw_inv
    assign tw_inv[g] = N'(modpow(W_INV, g, Q));
  end

  assign tw    = inv_r ? tw_inv[tidx] : tw_fwd[tidx];
  assign sprod = {{N{1'b0}}, mem[idx]} * DI2;
  assign rdata = inv_r ? N'(sprod % Q2) : mem[idx];
`else
  assign tw    = tw_fwd[tidx];
  assign rdata = mem[idx];
`endif

  assign in_ext   = {1'b0, in_data};
  assign in_red   = N'((in_ext >= QN) ? in_ext - QN : in_ext);
  assign out_data = out_valid ? rdata : '0;

  // Butterfly j of stage s pairs lo/hi = lo+2^s with twiddle exponent (j mod 2^s) * D/2^(s+1)
  always_comb begin
    int jj;
    int hh;
    jj   = int'(bj);
    hh   = 1 << stg;
    lo   = LG'(((jj >> stg) << (stg + 1)) | (jj & (hh - 1)));
    hi   = lo + LG'(hh);
    tidx = (LG-1)'((jj & (hh - 1)) << (LG - 1 - int'(stg)));
  end

  ntt_butterfly #(.N(N), .Q(Q)) u_bf (
    .a (mem[lo]),
    .b (mem[hi]),
    .t (tw),
    .x (bf_x),
    .y (bf_y)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == LOAD && in_valid && in_ready) begin
        mem[LG'(bitrev(int'(idx), LG))] <= in_red;
      end else if (state == COMPUTE) begin
        mem[lo] <= bf_x;
        mem[hi] <= bf_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      bj        <= '0;
      stg       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef NTT_ITER_INTT_EN
      inv_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // the done cycle is already IDLE; a start there is deliberately dropped
          if (start && !done) begin
            state    <= LOAD;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            idx      <= '0;
`ifdef NTT_ITER_INTT_EN
            inv_r    <= inverse;
`endif
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (idx == LG'(D - 1)) begin
              state    <= COMPUTE;
              in_ready <= 1'b0;
              idx      <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (bj == (LG-1)'(HD - 1)) begin
            bj <= '0;
            if (stg == SW'(LG - 1)) begin
              stg       <= '0;
              state     <= UNLOAD;
              out_valid <= 1'b1;
            end else begin
              stg <= stg + 1'b1;
            end
          end else begin
            bj <= bj + 1'b1;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            if (idx == LG'(D - 1)) begin
              idx       <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
